// File: rtl/wb_regbank_pkg.sv
// Shared types and helpers for the Wishbone register bank with external slots.
package wb_regbank_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INT      = 3'd1,
        ST_EXT_REQ  = 3'd2,
        ST_EXT_WAIT = 3'd3,
        ST_RESP     = 3'd4
    } state_e;

    localparam logic RESP_ACK = 1'b0;
    localparam logic RESP_ERR = 1'b1;

    // Ceiling log2, never below 1 so the result can always size a port.
    function automatic int clog2(input int value);
        int res;
        res = 1;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_regbank_reg.sv
// One internal register: byte-lane writes, one-cycle write strobe, optional read-only mode.
module wb_regbank_reg #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter bit                RO        = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [DATA_W/8-1:0] sel,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   ro_val,
    output logic [DATA_W-1:0]   q,
    output logic [DATA_W-1:0]   rdata,
    output logic                wstrb
);

    logic [DATA_W-1:0] q_r;
    logic              wstrb_r;

    // Register update; a read-only register never changes and never strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r     <= RESET_VAL;
            wstrb_r <= 1'b0;
        end else if (wr_en && !RO) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (sel[b]) begin
                    q_r[b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
            wstrb_r <= 1'b1;
        end else begin
            wstrb_r <= 1'b0;
        end
    end

    assign q     = q_r;
    assign rdata = RO ? ro_val : q_r;
    assign wstrb = wstrb_r;

endmodule

// File: rtl/wb_regbank_ext.sv
// Wishbone pipelined register bank: internal RW/RO registers plus external slots
// reached through a request/ack handshake guarded by a timeout.
module wb_regbank_ext
    import wb_regbank_pkg::*;
#(
    parameter int                          DATA_W    = 32,
    parameter int                          NUM_REGS  = 4,
    parameter int                          NUM_EXT   = 2,
    parameter logic [NUM_REGS-1:0]         RO_MASK   = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VAL = '0,
    parameter int                          TIMEOUT   = 16,
    parameter int                          ADDR_W    = clog2(NUM_REGS + NUM_EXT),
    parameter int                          EXT_AW    = clog2(NUM_EXT)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_we_i,
    input  logic [ADDR_W-1:0]          wb_adr_i,
    input  logic [DATA_W/8-1:0]        wb_sel_i,
    input  logic [DATA_W-1:0]          wb_dat_i,
    output logic                       wb_ack_o,
    output logic                       wb_err_o,
    output logic                       wb_rty_o,
    output logic                       wb_stall_o,
    output logic [DATA_W-1:0]          wb_dat_o,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    input  logic [NUM_REGS*DATA_W-1:0] regs_i,
    output logic [NUM_REGS-1:0]        wstrb_o,
    output logic [EXT_AW-1:0]          ext_addr_o,
    output logic [DATA_W-1:0]          ext_wdata_o,
    output logic [DATA_W/8-1:0]        ext_sel_o,
    output logic                       ext_wr_o,
    output logic                       ext_rd_o,
    input  logic [DATA_W-1:0]          ext_rdata_i,
    input  logic                       ext_ack_i
);

    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = clog2(TIMEOUT);
    localparam logic [ADDR_W:0] INT_LIM = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W:0] EXT_LIM = (ADDR_W+1)'(NUM_REGS + NUM_EXT);

    state_e              state_r;
    state_e              state_next_s;
    logic [ADDR_W-1:0]   adr_r;
    logic                we_r;
    logic [SEL_W-1:0]    sel_r;
    logic [DATA_W-1:0]   dat_r;
    logic [CNT_W-1:0]    cnt_r;

    logic                resp_go_s;
    logic                resp_type_s;
    logic [DATA_W-1:0]   resp_dat_s;
    logic                ext_go_s;
    logic [EXT_AW-1:0]   ext_idx_s;
    logic [DATA_W-1:0]   int_rdata_s;

    logic [NUM_REGS-1:0] reg_wr_s;
    logic [DATA_W-1:0]   reg_rdata_s [NUM_REGS];

    logic                wb_ack_r;
    logic                wb_err_r;
    logic                wb_stall_r;
    logic [DATA_W-1:0]   wb_dat_r;
    logic [EXT_AW-1:0]   ext_addr_r;
    logic [DATA_W-1:0]   ext_wdata_r;
    logic [SEL_W-1:0]    ext_sel_r;
    logic                ext_wr_r;
    logic                ext_rd_r;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign reg_wr_s[gi] = (state_r == ST_INT) && we_r && (adr_r == ADDR_W'(gi));

            wb_regbank_reg #(
                .DATA_W    (DATA_W),
                .RESET_VAL (RESET_VAL[gi*DATA_W +: DATA_W]),
                .RO        (RO_MASK[gi])
            ) u_reg (
                .clk    (clk_i),
                .rst    (rst_i),
                .wr_en  (reg_wr_s[gi]),
                .sel    (sel_r),
                .wdata  (dat_r),
                .ro_val (regs_i[gi*DATA_W +: DATA_W]),
                .q      (regs_o[gi*DATA_W +: DATA_W]),
                .rdata  (reg_rdata_s[gi]),
                .wstrb  (wstrb_o[gi])
            );
        end
    endgenerate

    // Internal read mux over the latched word address.
    always_comb begin
        int_rdata_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            int_rdata_s = int_rdata_s | ((adr_r == ADDR_W'(i)) ? reg_rdata_s[i] : '0);
        end
    end

    assign ext_idx_s = EXT_AW'(wb_adr_i - ADDR_W'(NUM_REGS));

    // Next-state and response decode.
    always_comb begin
        state_next_s = state_r;
        resp_go_s    = 1'b0;
        resp_type_s  = RESP_ACK;
        resp_dat_s   = '0;
        ext_go_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    if ({1'b0, wb_adr_i} < INT_LIM) begin
                        state_next_s = ST_INT;
                    end else if ({1'b0, wb_adr_i} < EXT_LIM) begin
                        state_next_s = ST_EXT_REQ;
                        ext_go_s     = 1'b1;
                    end else begin
                        state_next_s = ST_RESP;
                        resp_go_s    = 1'b1;
                        resp_type_s  = RESP_ERR;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_INT: begin
                state_next_s = ST_RESP;
                resp_go_s    = 1'b1;
                resp_dat_s   = we_r ? '0 : int_rdata_s;
            end
            ST_EXT_REQ, ST_EXT_WAIT: begin
                if (ext_ack_i) begin
                    state_next_s = ST_RESP;
                    resp_go_s    = 1'b1;
                    resp_dat_s   = we_r ? '0 : ext_rdata_i;
                end else if ((state_r == ST_EXT_WAIT) && (cnt_r == CNT_W'(TIMEOUT - 1))) begin
                    state_next_s = ST_RESP;
                    resp_go_s    = 1'b1;
                    resp_type_s  = RESP_ERR;
                end else begin
                    state_next_s = ST_EXT_WAIT;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request latch, timeout counter and registered bus/external outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            adr_r       <= '0;
            we_r        <= 1'b0;
            sel_r       <= '0;
            dat_r       <= '0;
            cnt_r       <= '0;
            wb_ack_r    <= 1'b0;
            wb_err_r    <= 1'b0;
            wb_stall_r  <= 1'b0;
            wb_dat_r    <= '0;
            ext_addr_r  <= '0;
            ext_wdata_r <= '0;
            ext_sel_r   <= '0;
            ext_wr_r    <= 1'b0;
            ext_rd_r    <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && wb_cyc_i && wb_stb_i) begin
                adr_r <= wb_adr_i;
                we_r  <= wb_we_i;
                sel_r <= wb_sel_i;
                dat_r <= wb_dat_i;
            end
            if (state_r == ST_EXT_REQ) begin
                cnt_r <= '0;
            end else if (state_r == ST_EXT_WAIT) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            wb_ack_r   <= resp_go_s && (resp_type_s == RESP_ACK);
            wb_err_r   <= resp_go_s && (resp_type_s == RESP_ERR);
            wb_stall_r <= (state_next_s != ST_IDLE);
            if (resp_go_s) begin
                wb_dat_r <= resp_dat_s;
            end
            ext_wr_r <= ext_go_s && wb_we_i;
            ext_rd_r <= ext_go_s && !wb_we_i;
            // External request fields stay valid until the response has gone out.
            if (ext_go_s) begin
                ext_addr_r  <= ext_idx_s;
                ext_wdata_r <= wb_dat_i;
                ext_sel_r   <= wb_sel_i;
            end else if (state_r == ST_RESP) begin
                ext_addr_r  <= '0;
                ext_wdata_r <= '0;
                ext_sel_r   <= '0;
            end
        end
    end

    assign wb_ack_o    = wb_ack_r;
    assign wb_err_o    = wb_err_r;
    assign wb_rty_o    = 1'b0;
    assign wb_stall_o  = wb_stall_r;
    assign wb_dat_o    = wb_dat_r;
    assign ext_addr_o  = ext_addr_r;
    assign ext_wdata_o = ext_wdata_r;
    assign ext_sel_o   = ext_sel_r;
    assign ext_wr_o    = ext_wr_r;
    assign ext_rd_o    = ext_rd_r;

endmodule

// File: tb/tb_wb_regbank_ext.sv
// Randomized self-checking bench for wb_regbank_ext against a transaction-level model.
module tb_wb_regbank_ext;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int NE = 2;
    localparam int TO = 16;
    localparam int AW = 3;
    localparam logic [NR-1:0]    RO_M  = 4'b0100;
    localparam logic [NR*DW-1:0] RST_V = {32'h1357_9BDF, 32'h5555_AAAA, 32'hDEAD_BEEF, 32'h0000_0000};

    logic              clk = 1'b0;
    logic              rst_i = 1'b0;
    logic              wb_cyc = 1'b0;
    logic              wb_stb = 1'b0;
    logic              wb_we = 1'b0;
    logic [AW-1:0]     wb_adr = '0;
    logic [3:0]        wb_sel = '0;
    logic [DW-1:0]     wb_dat = '0;
    logic              wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o;
    logic [DW-1:0]     wb_dat_o;
    logic [NR*DW-1:0]  regs_o;
    logic [NR*DW-1:0]  regs_in = '0;
    logic [NR-1:0]     wstrb_o;
    logic [0:0]        ext_addr_o;
    logic [DW-1:0]     ext_wdata_o;
    logic [3:0]        ext_sel_o;
    logic              ext_wr_o, ext_rd_o;
    logic [DW-1:0]     ext_rdata = '0;
    logic              ext_ack = 1'b0;

    int                checks_cnt = 0;
    int                errors_cnt = 0;
    logic [DW-1:0]     model_q [NR];
    logic [DW-1:0]     ro_vals [NR];

    wb_regbank_ext #(
        .DATA_W (DW), .NUM_REGS (NR), .NUM_EXT (NE),
        .RO_MASK (RO_M), .RESET_VAL (RST_V), .TIMEOUT (TO)
    ) dut (
        .clk_i (clk), .rst_i (rst_i),
        .wb_cyc_i (wb_cyc), .wb_stb_i (wb_stb), .wb_we_i (wb_we),
        .wb_adr_i (wb_adr), .wb_sel_i (wb_sel), .wb_dat_i (wb_dat),
        .wb_ack_o (wb_ack_o), .wb_err_o (wb_err_o), .wb_rty_o (wb_rty_o),
        .wb_stall_o (wb_stall_o), .wb_dat_o (wb_dat_o),
        .regs_o (regs_o), .regs_i (regs_in), .wstrb_o (wstrb_o),
        .ext_addr_o (ext_addr_o), .ext_wdata_o (ext_wdata_o), .ext_sel_o (ext_sel_o),
        .ext_wr_o (ext_wr_o), .ext_rd_o (ext_rd_o),
        .ext_rdata_i (ext_rdata), .ext_ack_i (ext_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] model_regs();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = model_q[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model_q[i] = RST_V[i*DW +: DW];
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ack", wb_ack_o, 0);
        chk("rst_err", wb_err_o, 0);
        chk("rst_stall", wb_stall_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_wstrb", wstrb_o, 0);
        chk("rst_ext", {ext_addr_o, ext_wdata_o, ext_sel_o, ext_wr_o, ext_rd_o}, 0);
        chk("rst_regs", regs_o, RST_V);
    endtask

    // One Wishbone transaction; dly<0 means the external responder stays silent.
    task automatic run_txn(input logic [AW-1:0] adr, input logic we, input logic [3:0] sel,
                           input logic [DW-1:0] dat, input int dly, input logic [DW-1:0] erd,
                           input bit drop);
        int a, lat, pulse_cyc, n_rd, n_wr, n_strb, exp_lat;
        bit is_int, is_ext, exp_err, got;
        logic [DW-1:0] exp_dat, r_dat;
        logic [NR-1:0] exp_strb, r_strb;
        logic r_ack, r_err, r_rty;
        a = int'(adr);
        is_int  = (a < NR);
        is_ext  = !is_int && (a < NR + NE);
        exp_err = !(is_int || is_ext) || (is_ext && dly < 0);
        exp_lat = is_int ? 2 : (is_ext ? 2 + dly : 1);
        exp_dat = '0;
        if (!exp_err && !we) exp_dat = is_int ? (RO_M[a] ? ro_vals[a] : model_q[a]) : erd;
        exp_strb = '0;
        if (is_int && we && !RO_M[a]) begin
            exp_strb[a] = 1'b1;
            for (int b = 0; b < 4; b++) if (sel[b]) model_q[a][b*8 +: 8] = dat[b*8 +: 8];
        end

        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat = dat;
        @(posedge clk); #1;
        wb_stb = 1'b0;
        if (drop) wb_cyc = 1'b0;
        chk("stall_busy", wb_stall_o, 1);

        lat = 1; pulse_cyc = -1; n_rd = 0; n_wr = 0; n_strb = 0; got = 1'b0;
        r_ack = 0; r_err = 0; r_rty = 0; r_dat = '0; r_strb = '0;
        while (!got && lat <= TO + 8) begin
            ext_ack = 1'b0;
            if (ext_rd_o || ext_wr_o) begin
                n_rd += int'(ext_rd_o);
                n_wr += int'(ext_wr_o);
                pulse_cyc = lat;
                chk("ext_addr", ext_addr_o, a - NR);
                if (we) begin
                    chk("ext_wdata", ext_wdata_o, dat);
                    chk("ext_sel", ext_sel_o, sel);
                end
            end
            if (pulse_cyc >= 0 && dly >= 0 && lat == pulse_cyc + dly) begin
                ext_ack = 1'b1;
                ext_rdata = erd;
            end
            n_strb += $countones(wstrb_o);
            if (wb_ack_o || wb_err_o) begin
                got = 1'b1;
                r_ack = wb_ack_o; r_err = wb_err_o; r_rty = wb_rty_o;
                r_dat = wb_dat_o; r_strb = wstrb_o;
            end else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        ext_ack = 1'b0;

        chk("resp_seen", got, 1);
        if (got) begin
            chk("resp_ack", r_ack, !exp_err);
            chk("resp_err", r_err, exp_err);
            chk("resp_rty", r_rty, 0);
            chk("resp_dat", r_dat, exp_dat);
            chk("strb_at_ack", r_strb, exp_strb);
            if (is_ext && dly < 0) chk("timeout_lat", (lat >= TO) && (lat <= TO + 2), 1);
            else chk("latency", lat, exp_lat);
        end
        chk("strb_count", n_strb, $countones(exp_strb));
        chk("ext_rd_count", n_rd, (is_ext && !we) ? 1 : 0);
        chk("ext_wr_count", n_wr, (is_ext && we) ? 1 : 0);
        chk("regs_o", regs_o, model_regs());

        @(posedge clk); #1;
        wb_cyc = 1'b0;
        chk("idle_stall", wb_stall_o, 0);
        chk("resp_cleared", {wb_ack_o, wb_err_o}, 0);
        chk("dat_hold", wb_dat_o, exp_dat);
    endtask

    initial begin
        int dly;
        ro_vals[0] = 32'h0BAD_0000; ro_vals[1] = 32'h0BAD_0001;
        ro_vals[2] = 32'hCAFE_0001; ro_vals[3] = 32'h0BAD_0003;
        for (int i = 0; i < NR; i++) regs_in[i*DW +: DW] = ro_vals[i];
        model_reset();

        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        chk("rst_slice1", regs_o[2*DW-1:DW], 32'hDEAD_BEEF);
        rst_i = 1'b0;
        @(posedge clk); #1;

        run_txn(3'd1, 1'b0, 4'hF, 32'h0, 0, 32'h0, 1'b0);
        run_txn(3'd0, 1'b1, 4'b0101, 32'h1122_3344, 0, 32'h0, 1'b0);
        chk("byte_write", regs_o[DW-1:0], 32'h0022_0044);
        run_txn(3'd2, 1'b1, 4'hF, 32'hFFFF_FFFF, 0, 32'h0, 1'b0);
        run_txn(3'd2, 1'b0, 4'hF, 32'h0, 0, 32'h0, 1'b0);
        run_txn(3'd5, 1'b0, 4'hF, 32'h0, 3, 32'hA5A5_A5A5, 1'b0);
        run_txn(3'd4, 1'b1, 4'h3, 32'h7777_1234, -1, 32'h0, 1'b0);

        // A late external ack while idle must produce nothing.
        ext_ack = 1'b1; ext_rdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        ext_ack = 1'b0;
        chk("late_ack_ignored", {wb_ack_o, wb_err_o, wb_stall_o}, 0);
        @(posedge clk); #1;
        chk("late_ack_ignored2", {wb_ack_o, wb_err_o, wb_stall_o}, 0);
        run_txn(3'd1, 1'b0, 4'hF, 32'h0, 0, 32'h0, 1'b0);
        run_txn(3'd6, 1'b0, 4'hF, 32'h0, 0, 32'h0, 1'b0);

        // Reset while waiting on a silent external slot.
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 3'd4; wb_sel = 4'hF; wb_dat = 32'h1;
        @(posedge clk); #1;
        wb_stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_busy", wb_stall_o, 1);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        wb_cyc = 1'b0;
        model_reset();
        chk_reset_outputs();
        for (int i = 0; i < TO + 4; i++) begin
            @(posedge clk); #1;
            chk("abandoned_no_resp", {wb_ack_o, wb_err_o}, 0);
        end

        for (int n = 0; n < 60; n++) begin
            dly = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TO - 2));
            run_txn(AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'($urandom),
                    $urandom, dly, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/wb_regbank_ext.md
Name: wb_regbank_ext

Overview:
- Parametrised Wishbone (classic pipelined) register bank.
- Provides NUM_REGS internal registers, each either RW or RO (per-bit mask), with byte-lane writes and per-register write strobes.
- Provides NUM_EXT external register slots behind a request/ack handshake, with a bus-error timeout.
- Sits between the Wishbone interconnect and a peripheral core, replacing fixed-layout single-register blocks.

Parameters:
- DATA_W, 32, data width; multiple of 8.
- NUM_REGS, 4, internal registers at word addresses 0..NUM_REGS-1; ≥1.
- NUM_EXT, 2, external slots at word addresses NUM_REGS..NUM_REGS+NUM_EXT-1; ≥1.
- RO_MASK, all zeros, NUM_REGS bits; bit i=1 makes register i read-only, sourced from regs_i.
- RESET_VAL, all zeros, NUM_REGS*DATA_W bits; reset value of register i is slice i.
- TIMEOUT, 16, cycles to wait for ext_ack_i before erroring; ≥2.
- ADDR_W, clog2(NUM_REGS+NUM_EXT), word address width (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone control.
- wb_adr_i  in  ADDR_W  word address.
- wb_sel_i  in  DATA_W/8  byte lanes.
- wb_dat_i  in  DATA_W  write data.
- wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o  out  1 each  Wishbone response.
- wb_dat_o  out  DATA_W  read data.
- regs_o  out  NUM_REGS*DATA_W  internal register contents.
- regs_i  in  NUM_REGS*DATA_W  read values for RO registers.
- wstrb_o  out  NUM_REGS  one-cycle write pulse per register.
- ext_addr_o  out  clog2(NUM_EXT) (min 1)  external slot index.
- ext_wdata_o  out  DATA_W  external write data.
- ext_sel_o  out  DATA_W/8  external byte lanes.
- ext_wr_o, ext_rd_o  out  1  one-cycle external request pulses.
- ext_rdata_i  in  DATA_W  external read data, valid with ext_ack_i.
- ext_ack_i  in  1  external completion.

Behaviour:
- Reset, synchronous on rst_i=1:
  - regs_o = RESET_VAL; all other outputs 0.
  - FSM to IDLE; timeout counter 0.
  - Any transaction in progress is abandoned; no ack or err is issued for it.
- wb_rty_o is constant 0.
- wb_stall_o = 1 in every state except IDLE.
- FSM states: IDLE, INT, EXT_REQ, EXT_WAIT, RESP.
- IDLE, on wb_cyc_i & wb_stb_i (accept cycle T0):
  - Latch adr, we, sel, dat.
  - Go to INT if addr < NUM_REGS.
  - Go to EXT_REQ if addr < NUM_REGS+NUM_EXT.
  - Otherwise go to RESP with err=1.
- INT (T1):
  - Write to an RW register: bytes with sel=1 are updated; wstrb_o[i]=1 in T2, aligned with the new regs_o value.
  - Write to an RO register: no update, no strobe, still acked.
  - Read: capture the register value, or the regs_i slice for RO.
  - Go to RESP.
- EXT_REQ (T1):
  - Pulse ext_wr_o or ext_rd_o for exactly one cycle.
  - ext_addr_o = addr-NUM_REGS; ext_wdata_o and ext_sel_o held until the response.
  - Clear the counter; go to EXT_WAIT.
  - ext_ack_i in the request cycle itself is accepted.
- EXT_WAIT:
  - On ext_ack_i: capture ext_rdata_i on reads; go to RESP with ack.
  - If the counter reaches TIMEOUT-1 without ack: go to RESP with err=1, wb_dat_o=0.
  - A late ext_ack_i arriving in IDLE is ignored.
- RESP: exactly one of wb_ack_o/wb_err_o high for one cycle; wb_dat_o valid with it; return to IDLE.
- Latency, accept to ack:
  - Internal: 2 cycles (ack at T2).
  - Out-of-range: 1 cycle (err at T1).
  - External with immediate ack: 2 cycles minimum.
- wb_dat_o holds its last value outside RESP. On write responses and error responses it is driven to 0.
- wb_cyc_i dropped mid-transaction: the FSM completes normally (the external request is not cancelled), and the response is still pulsed.
- Back-to-back requests: a new request is accepted in the cycle after RESP, at the earliest. Throughput is 1 transaction per 3 cycles for internal accesses.

Decomposition:
- Package wb_regbank_pkg holds:
  - FSM state enum.
  - clog2 function.
  - Response-type constants (ACK/ERR).
- Sub-module wb_regbank_reg: one internal register with DATA_W, RESET_VAL and RO generics, byte-enable write and strobe output, instantiated NUM_REGS times in a generate loop.

Test Plan:
1. Reset with RESET_VAL slice 1 = 0xDEADBEEF → regs_o slice 1 reads 0xDEADBEEF; read of addr 1 returns 0xDEADBEEF with ack at T2.
2. Write 0x11223344 with sel=0b0101 to addr 0 (reset value 0) → register 0 = 0x00220044; wstrb_o[0] pulses once; no other strobe fires.
3. With RO_MASK bit 2 set and regs_i slice 2 = 0xCAFE0001: write 0xFFFFFFFF to addr 2 → acked, no strobe; subsequent read returns 0xCAFE0001.
4. Read ext slot 1 (addr NUM_REGS+1); responder acks 3 cycles after ext_rd_o with 0xA5A5A5A5 → ext_addr_o=1, single ext_rd_o pulse, wb_ack_o with 0xA5A5A5A5.
5. Write ext slot 0 with the responder silent → wb_err_o after TIMEOUT cycles, no ack; a late ext_ack_i is ignored; the next internal read succeeds.
6. Access addr NUM_REGS+NUM_EXT → wb_err_o at T1. Separately, assert rst_i while in EXT_WAIT → no response, all outputs 0, regs_o = RESET_VAL.
